// File: rtl/fc_argmax.sv
// ---------------------------------------------------------------------------
// fc_argmax
//   Final classification stage of the CNN pipeline. Consumes the serial
//   stream of signed class scores from the fully-connected layer (class 0
//   first, NUM_CLASS scores per image). It tracks the running maximum and
//   emits the winning class index and its score once per frame.
//
//   Optional feature macro: ARGMAX_MARGIN_EN
//     When defined, the second-best score is also tracked. margin_out then
//     reports (best - second best), and low_conf flags a margin below
//     MARGIN_THR. When undefined, both outputs are tied to zero and no
//     second-best logic exists.
//
//   Handshake: a sample is taken on every rising clk edge where valid_in is
//   high and clear is low. There is no back-pressure. decision_valid is a
//   one-cycle pulse in the cycle after the last sample of a frame is taken,
//   and class_out/score_out/margin_out/low_conf change only on that edge.
//
//   Control: the sample counter is the state. COLLECT covers counts
//   0..NUM_CLASS-2 and LAST is count NUM_CLASS-1. The state is visible as the
//   internal 'state' signal.
// ---------------------------------------------------------------------------
module fc_argmax #(
    parameter int NUM_CLASS  = 10,
    parameter int DATA_BITS  = 12,
    parameter int IDX_BITS   = 4,
    parameter int MARGIN_THR = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        valid_in,
    input  logic signed [DATA_BITS-1:0] data_in,
    output logic        [IDX_BITS-1:0]  class_out,
    output logic signed [DATA_BITS-1:0] score_out,
    output logic                        decision_valid,
    output logic                        busy,
    output logic        [DATA_BITS:0]   margin_out,
    output logic                        low_conf
);

    // Reject parameter sets that cannot index every class.
    if (NUM_CLASS < 2 || (2 ** IDX_BITS) < NUM_CLASS || MARGIN_THR < 0) begin : g_param_check
        $error("fc_argmax: illegal parameter combination");
    end

    localparam logic [IDX_BITS-1:0]         LAST_IDX = IDX_BITS'(NUM_CLASS - 1);
    localparam logic [IDX_BITS-1:0]         ONE_IDX  = IDX_BITS'(1);
    localparam logic signed [DATA_BITS-1:0] MOST_NEG = {1'b1, {(DATA_BITS - 1){1'b0}}};

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_LAST    = 1'b1
    } state_t;

    state_t                      state;

    logic [IDX_BITS-1:0]         cnt_q,     cnt_d;
    logic signed [DATA_BITS-1:0] run_max_q, run_max_d;
    logic [IDX_BITS-1:0]         run_idx_q, run_idx_d;
    logic [IDX_BITS-1:0]         class_q,   class_d;
    logic signed [DATA_BITS-1:0] score_q,   score_d;
    logic                        dv_q,      dv_d;
    logic                        busy_q,    busy_d;

    // Best-so-far including the sample currently on data_in.
    logic signed [DATA_BITS-1:0] cand_max;
    logic [IDX_BITS-1:0]         cand_idx;

    // Decode the control state from the sample counter.
    always_comb begin
        state = (cnt_q == LAST_IDX) ? ST_LAST : ST_COLLECT;
    end

    // Running-max compare: sample 0 always seeds, later samples need a strict
    // signed win so ties keep the lower index.
    always_comb begin
        cand_max = run_max_q;
        cand_idx = run_idx_q;
        if (cnt_q == '0) begin
            cand_max = data_in;
            cand_idx = '0;
        end else if (data_in > run_max_q) begin
            cand_max = data_in;
            cand_idx = cnt_q;
        end
    end

    // Next-state and output-register logic; clear outranks valid_in.
    always_comb begin
        cnt_d     = cnt_q;
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
        class_d   = class_q;
        score_d   = score_q;
        dv_d      = 1'b0;
        if (clear) begin
            cnt_d     = '0;
            run_max_d = '0;
            run_idx_d = '0;
        end else if (valid_in) begin
            run_max_d = cand_max;
            run_idx_d = cand_idx;
            case (state)
                ST_LAST: begin
                    cnt_d   = '0;
                    class_d = cand_idx;
                    score_d = cand_max;
                    dv_d    = 1'b1;
                end
                default: begin
                    cnt_d = cnt_q + ONE_IDX;
                end
            endcase
        end
        busy_d = (cnt_d != '0);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            run_max_q <= '0;
            run_idx_q <= '0;
            class_q   <= '0;
            score_q   <= '0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
            class_q   <= class_d;
            score_q   <= score_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
        end
    end

    assign class_out      = class_q;
    assign score_out      = score_q;
    assign decision_valid = dv_q;
    assign busy           = busy_q;

`ifdef ARGMAX_MARGIN_EN
    localparam logic [DATA_BITS:0] THR = (DATA_BITS + 1)'(MARGIN_THR);

    logic signed [DATA_BITS-1:0] run_sec_q, run_sec_d;
    logic signed [DATA_BITS-1:0] cand_sec;
    logic signed [DATA_BITS:0]   ext_max;
    logic signed [DATA_BITS:0]   ext_sec;
    logic signed [DATA_BITS:0]   diff;
    logic [DATA_BITS:0]          margin_q, margin_d;
    logic                        low_q,    low_d;

    // Second-best tracking: a new max demotes the old max; a tie with the
    // max lands here as second, giving margin 0.
    always_comb begin
        cand_sec = run_sec_q;
        if (cnt_q == '0) begin
            cand_sec = MOST_NEG;
        end else if (data_in > run_max_q) begin
            cand_sec = run_max_q;
        end else if (data_in > run_sec_q) begin
            cand_sec = data_in;
        end
    end

    // Margin is formed one bit wider than the scores so it cannot overflow.
    always_comb begin
        ext_max   = {cand_max[DATA_BITS-1], cand_max};
        ext_sec   = {cand_sec[DATA_BITS-1], cand_sec};
        diff      = ext_max - ext_sec;
        run_sec_d = run_sec_q;
        margin_d  = margin_q;
        low_d     = low_q;
        if (clear) begin
            run_sec_d = MOST_NEG;
        end else if (valid_in) begin
            run_sec_d = cand_sec;
            if (state == ST_LAST) begin
                margin_d = diff;
                low_d    = (diff < THR);
            end
        end
    end

    // Second-best and margin registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_sec_q <= MOST_NEG;
            margin_q  <= '0;
            low_q     <= 1'b0;
        end else begin
            run_sec_q <= run_sec_d;
            margin_q  <= margin_d;
            low_q     <= low_d;
        end
    end

    assign margin_out = margin_q;
    assign low_conf   = low_q;
`else
    assign margin_out = '0;
    assign low_conf   = 1'b0;
`endif

endmodule

// File: doc/fc_argmax.md
Name: fc_argmax

Overview:
- Sits directly downstream of the fully-connected layer and consumes its serial stream of class scores.
- Input is one signed 12-bit score per valid pulse, classes 0..NUM_CLASS-1 in order, repeating per image.
- Tracks the running maximum and emits the winning class index plus its score once per frame.
- Final classification stage of the CNN pipeline.

Parameters:
- NUM_CLASS, 10, scores per frame; must be >= 2.
- DATA_BITS, 12, width of the signed input score.
- IDX_BITS, 4, width of class index; must satisfy 2^IDX_BITS >= NUM_CLASS.
- MARGIN_THR, 16, low-confidence threshold. Used only with ARGMAX_MARGIN_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- clear  in  1  synchronous frame resync: discards the partial frame and sets the next sample to class 0.
- valid_in  in  1  qualifies data_in; may be high on consecutive cycles.
- data_in  in  DATA_BITS  class score, always treated as signed two's complement.
- class_out  out  IDX_BITS  winning class index, held until the next decision.
- score_out  out  DATA_BITS  winning score, signed, held.
- decision_valid  out  1  one-cycle pulse when class_out/score_out update.
- busy  out  1  high while a frame is partially collected (sample count != 0).
- margin_out  out  DATA_BITS+1  best minus second-best score, unsigned. Zero when the feature is absent.
- low_conf  out  1  margin_out < MARGIN_THR, valid with decision_valid, held. Zero when the feature is absent.

Behaviour:
- Reset (rst=1 at clk edge): sample counter=0, running max/index cleared, class_out=0, score_out=0, decision_valid=0, busy=0, margin_out=0, low_conf=0.
  - Reset mid-frame abandons the frame; no decision is emitted.
- States:
  - COLLECT: counter 0..NUM_CLASS-2.
  - LAST: counter = NUM_CLASS-1.
  - Implemented as a counter plus a registered pulse; no idle wait state is needed.
- Sample 0 of a frame: run_max <= data_in, run_idx <= 0, unconditionally.
  - No dependency on previous-frame state.
- Sample k>0: if data_in > run_max (signed, strict), then run_max <= data_in and run_idx <= k.
  - Ties keep the lower index.
- Accepting sample NUM_CLASS-1:
  - Final compare is combinational against run_max.
  - class_out/score_out registered on that same edge.
  - decision_valid=1 for exactly the following cycle (latency 1 clk after the last valid_in).
  - Counter wraps to 0.
- Back-to-back frames: valid_in on the cycle decision_valid is high is sample 0 of the next frame.
  - Accepted with no bubble.
  - Held outputs remain until the next decision.
- valid_in=0 cycles: no state change; the counter does not time out.
- clear=1:
  - Counter <= 0 and the running state is discarded.
  - clear outranks a simultaneous valid_in; that sample is dropped.
  - class_out/score_out are not modified.
  - decision_valid is not suppressed if it was already scheduled from the prior edge.
- rst outranks clear and valid_in.
- busy = (counter != 0), registered.
- All-equal scores: class_out=0.
- Most negative score (-2048) must compare correctly; no unsigned compare anywhere.

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- Defined:
  - Also track run_second, the second-highest score.
  - Sample 0 sets run_second to the most negative value.
  - On a new max, run_second <= old run_max.
  - Otherwise, if data_in > run_second, run_second <= data_in.
  - A tie with run_max counts as second (margin 0).
  - At decision: margin_out = run_max - run_second, computed DATA_BITS+1 wide, never overflows.
  - low_conf = (margin_out < MARGIN_THR).
  - Both update with class_out.
- Undefined: no second-best logic is synthesized; margin_out and low_conf are tied to 0.

Test Plan:
- Reset then 10 back-to-back valid samples [5,-3,100,7,99,0,-2048,100,2047,1]:
  - class_out=8, score_out=2047, decision_valid high exactly 1 cycle after sample 9.
  - With macro: margin_out=1947, low_conf=0.
- All-negative frame [-10,-20,-5,-5,-2048,-100,-6,-7,-8,-9]:
  - class_out=2 (tie keeps lower), score_out=-5.
  - With macro: margin_out=0, low_conf=1.
- Two frames with continuous valid_in:
  - Frame A max at idx 3; frame B max at idx 0 with B scores all below A's max.
  - Two pulses 10 cycles apart; second pulse gives class_out=0 (no carry-over from A).
- Gapped valid_in (valid every 3rd cycle) with scores max at idx 9:
  - Decision 1 cycle after the 10th valid; busy high from sample 1 until the decision edge.
- After 4 samples assert clear together with valid_in, then send a full 10-sample frame (max idx 6):
  - Single decision with class_out=6; the dropped sample has no effect.
  - Prior class_out held until then.
- rst asserted after 5 samples, then a full frame:
  - Outputs read 0 during reset; no pulse for the aborted frame.
  - The correct decision follows the new frame.
